// File: rtl/gearbox_20to16_if.sv
// Handshake bundle between the 20-bit deframer side and the 16-bit core side of gearbox_20to16.
// Optional macro GEARBOX_ERR_EN adds the sticky err flag.
interface gearbox_20to16_if;
  logic        shift_in;
  logic [19:0] data_in;
  logic        full;
  logic        shift_out;
  logic        valid_out;
  logic [15:0] data_out;
`ifdef GEARBOX_ERR_EN
  logic        err;

  modport master (
    output shift_in, data_in, shift_out,
    input  full, valid_out, data_out, err
  );

  modport slave (
    input  shift_in, data_in, shift_out,
    output full, valid_out, data_out, err
  );
`else
  modport master (
    output shift_in, data_in, shift_out,
    input  full, valid_out, data_out
  );

  modport slave (
    input  shift_in, data_in, shift_out,
    output full, valid_out, data_out
  );
`endif
endinterface

// File: rtl/gearbox_20to16.sv
// 20-bit to 16-bit nibble gearbox: circular nibble buffer feeding a registered 16-bit output word.
// Optional macro GEARBOX_ERR_EN adds a sticky overflow/underflow flag (bus.err).
module gearbox_20to16 #(
  parameter int DEPTH = 32
) (
  input  logic            clk_400MHz,
  input  logic            res,
  gearbox_20to16_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]    r_buf [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic [15:0]   r_data;

  logic [CW-1:0] w_free;
  logic          w_write;
  logic          w_load;
  logic [15:0]   w_rd_word;
  logic [CW-1:0] w_count_nxt;

  assign w_free   = CW'(DEPTH) - r_count;
  assign bus.full = (w_free < CW'(5));
  assign w_write  = bus.shift_in && !bus.full;
  // Load looks at the registered count only, so a fresh word needs one extra edge.
  assign w_load   = (r_count >= CW'(4)) && (!r_valid || bus.shift_out);

  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < 4; k++) begin
      w_rd_word[4*k +: 4] = r_buf[r_rd_ptr + PW'(k)];
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_write) w_count_nxt = w_count_nxt + CW'(5);
    if (w_load)  w_count_nxt = w_count_nxt - CW'(4);
  end

  // Storage is intentionally not reset; count alone defines what is valid.
  always_ff @(posedge clk_400MHz) begin
    if (w_write) begin
      for (int k = 0; k < 5; k++) begin
        r_buf[r_wr_ptr + PW'(k)] <= bus.data_in[4*k +: 4];
      end
    end
  end

  always_ff @(posedge clk_400MHz or posedge res) begin
    if (res) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_data   <= 16'h0000;
    end else begin
      r_count <= w_count_nxt;
      if (w_write) r_wr_ptr <= r_wr_ptr + PW'(5);
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + PW'(4);
        r_data   <= w_rd_word;
        r_valid  <= 1'b1;
      end else if (bus.shift_out) begin
        r_valid  <= 1'b0;
      end
    end
  end

  assign bus.valid_out = r_valid;
  assign bus.data_out  = r_data;

`ifdef GEARBOX_ERR_EN
  logic r_err;

  always_ff @(posedge clk_400MHz or posedge res) begin
    if (res) begin
      r_err <= 1'b0;
    end else if ((bus.shift_in && bus.full) || (bus.shift_out && !r_valid)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`endif

endmodule
